mem_arbiter_2port: RTL and testbench

//   Shares one main-memory port between two cache requesters (port 0 = I-cache, port 1 = D-cache).

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/rr_arb2.sv | 19 +
 rtl/mem_arbiter_2port.sv | 112 +++++++++++
 tb/tb_mem_arbiter_2port.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cache-to-memory bus: state encoding, default
// widths and requester port indices.
package mem_bus_pkg;

  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 8;
  localparam int BURST_LEN_DEF = 4;

  localparam int PORT_ICACHE = 0;
  localparam int PORT_DCACHE = 1;

  typedef logic [1:0] mem_state_t;

  localparam mem_state_t ST_IDLE  = 2'd0;
  localparam mem_state_t ST_GRANT = 2'd1;
  localparam mem_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins, contention is
// resolved in favour of the port named by rr_ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = rr_ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_2port.sv
// Shares one burst-oriented memory port between the I-cache (port 0) and the
// D-cache (port 1); the granted port owns the bus until its burst completes.
module mem_arbiter_2port
  import mem_bus_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rd_0,
  input  logic          wr_0,
  input  logic [AW-1:0] addr_0,
  input  logic [DW-1:0] wdata_0,
  output logic [DW-1:0] rdata_0,
  output logic          ready_0,
  input  logic          rd_1,
  input  logic          wr_1,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_1,
  output logic [DW-1:0] rdata_1,
  output logic          ready_1,
  output logic [AW-1:0] addr_mem,
  output logic          rd_mem,
  output logic          wr_mem,
  output logic [DW-1:0] wdata_mem,
  input  logic [DW-1:0] rdata_mem,
  input  logic          ready_mem,
  output logic [1:0]    gnt,
  output logic          busy,
  output mem_state_t    state_dbg
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  // Handshake: a requester raises rd_x/wr_x and holds it; every cycle with
  // ready_x=1 is one completed beat (write data consumed or read data valid),
  // and after the BURST_LEN-th ready_x the requester may drop its request.

  mem_state_t      state;
  logic [BW-1:0]   beat;
  logic            rr_ptr;
  logic [1:0]      req;
  logic [1:0]      win;
  logic            win_wr;
  logic [AW-BW-1:0] win_line;
  logic            unused_addr_low;

  assign req      = {rd_1 | wr_1, rd_0 | wr_0};
  assign win_wr   = win[1] ? wr_1 : wr_0;
  assign win_line = win[1] ? addr_1[AW-1:BW] : addr_0[AW-1:BW];
  assign unused_addr_low = ^{addr_0[BW-1:0], addr_1[BW-1:0]};

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win    (win)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat     <= '0;
      rr_ptr   <= 1'b0;
      gnt      <= 2'b00;
      rd_mem   <= 1'b0;
      wr_mem   <= 1'b0;
      addr_mem <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            // Type is latched here; write wins so a write-back precedes its fill.
            gnt      <= win;
            wr_mem   <= win_wr;
            rd_mem   <= ~win_wr;
            addr_mem <= {win_line, {BW{1'b0}}};
            beat     <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (ready_mem) begin
            beat               <= beat + BEAT_ONE;
            addr_mem[BW-1:0]   <= beat + BEAT_ONE;
            if (beat == BEAT_LAST) begin
              rd_mem <= 1'b0;
              wr_mem <= 1'b0;
              gnt    <= 2'b00;
              rr_ptr <= gnt[0];
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready_0   = ready_mem & gnt[0] & (state == ST_GRANT);
  assign ready_1   = ready_mem & gnt[1] & (state == ST_GRANT);
  assign rdata_0   = rdata_mem;
  assign rdata_1   = rdata_mem;
  assign wdata_mem = gnt[1] ? wdata_1 : wdata_0;
  assign busy      = (state == ST_GRANT) || (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed bench for mem_arbiter_2port: drivers issue bursts, expected beats
// and grant order are queued up front and checked by negedge monitors.
module tb_mem_arbiter_2port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_0 = 0, wr_0 = 0, rd_1 = 0, wr_1 = 0;
  logic [15:0] addr_0 = '0, addr_1 = '0;
  logic [7:0]  wdata_0 = '0, wdata_1 = '0;
  logic [7:0]  rdata_0, rdata_1;
  logic        ready_0, ready_1;
  logic [15:0] addr_mem;
  logic        rd_mem, wr_mem;
  logic [7:0]  wdata_mem, rdata_mem;
  logic        ready_mem = 1'b0;
  logic [1:0]  gnt;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  mem_arbiter_2port dut (
    .clock(clock), .reset(reset),
    .rd_0(rd_0), .wr_0(wr_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .rdata_0(rdata_0), .ready_0(ready_0),
    .rd_1(rd_1), .wr_1(wr_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .rdata_1(rdata_1), .ready_1(ready_1),
    .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .wdata_mem(wdata_mem), .rdata_mem(rdata_mem), .ready_mem(ready_mem),
    .gnt(gnt), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  // ---------------- memory model ----------------
  // Read data is 11,22,33,44 for beats 0..3 of any line.
  logic gap_mode = 0, tog = 0, hold_mem = 0, force_rdy = 0;
  assign rdata_mem = 8'h11 * ({6'b0, addr_mem[1:0]} + 8'd1);

  always @(posedge clock) begin
    #1;
    if (hold_mem) ready_mem = 1'b0;
    else if (rd_mem || wr_mem) begin
      ready_mem = gap_mode ? tog : 1'b1;
      tog = ~tog;
    end else begin
      ready_mem = force_rdy;
      tog = 1'b0;
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Beat record: {port, wr_mem, rd_mem, addr_mem, data}
  logic [26:0] exp_q[$];
  logic [1:0]  exp_gnt_q[$];
  logic [26:0] sb_got, sb_exp;
  logic [1:0]  prev_gnt = 2'b00;
  int          cyc = 0, last_rise = 0, prev_rise = 0;

  function automatic logic [26:0] beat_rec(input logic p, input logic w, input logic [15:0] a,
                                           input logic [7:0] d);
    return {p, w, ~w, a, d};
  endfunction

  task automatic push_burst(input logic p, input logic w, input logic [15:0] base,
                            input logic [31:0] d_pk);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(beat_rec(p, w, base + 16'(i), d_pk[8*i +: 8]));
  endtask

  always @(negedge clock) begin
    if (ready_0 || ready_1) begin
      sb_got = {ready_1, wr_mem, rd_mem, addr_mem,
                wr_mem ? wdata_mem : (ready_1 ? rdata_1 : rdata_0)};
      if (ready_0 && ready_1) chk("ready_onehot", {30'b0, ready_1, ready_0}, 32'h1);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got=%h expected=none", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          errors++;
          $display("FAIL beat: got=%h expected=%h", sb_got, sb_exp);
        end
      end
    end
  end

  always @(negedge clock) begin
    cyc++;
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      prev_rise = last_rise;
      last_rise = cyc;
      checks++;
      if (exp_gnt_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got=%b expected=none", gnt);
      end else if (gnt !== exp_gnt_q[0]) begin
        errors++;
        $display("FAIL grant_order: got=%b expected=%b", gnt, exp_gnt_q[0]);
        void'(exp_gnt_q.pop_front());
      end else void'(exp_gnt_q.pop_front());
    end
    prev_gnt = gnt;
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic p, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [31:0] wd_pk, input int drop_at);
    int n = 0;
    int budget = 0;
    @(posedge clock); #1;
    if (p) begin rd_1 = rd; wr_1 = wr; addr_1 = a; wdata_1 = wd_pk[7:0]; end
    else   begin rd_0 = rd; wr_0 = wr; addr_0 = a; wdata_0 = wd_pk[7:0]; end
    while (n < 4 && budget < 200) begin
      @(negedge clock);
      if (p ? ready_1 : ready_0) n++;
      budget++;
      @(posedge clock); #1;
      if (n >= drop_at) begin
        if (p) begin rd_1 = 0; wr_1 = 0; end
        else   begin rd_0 = 0; wr_0 = 0; end
      end
      if (n < 4) begin
        if (p) wdata_1 = wd_pk[8*n +: 8];
        else   wdata_0 = wd_pk[8*n +: 8];
      end
    end
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL burst_timeout port%0d: got=%0d beats expected=4", p, n);
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [31:0] RD_DATA = 32'h44332211;
  localparam logic [31:0] WR_DATA = 32'hDDCCBBAA;

  initial begin
    int n;
    int budget;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_gnt", {30'b0, gnt}, 0);
    chk("reset_strobes", {30'b0, rd_mem, wr_mem}, 0);
    chk("reset_addr", {16'b0, addr_mem}, 0);
    chk("reset_busy_state", {29'b0, busy, state_dbg}, 0);

    // 1) port 0 line fill of C08B
    push_burst(0, 0, 16'hC088, RD_DATA);
    exp_gnt_q.push_back(2'b01);
    fork
      do_req(0, 1, 0, 16'hC08B, 0, 4);
      begin
        @(posedge clock); @(negedge clock);
        chk("t1_no_grant_yet", {30'b0, gnt}, 0);
        @(negedge clock);
        chk("t1_grant", {14'b0, gnt, addr_mem}, {14'b0, 2'b01, 16'hC088});
      end
    join
    @(negedge clock);
    chk("t1_done_state", {28'b0, rd_mem, gnt, busy}, 32'h1);
    @(negedge clock);
    chk("t1_idle", {29'b0, busy, state_dbg}, 0);

    // 2) simultaneous requests after reset: port 0 first, then port 1
    pulse_reset();
    push_burst(0, 0, 16'h4000, RD_DATA);
    push_burst(1, 0, 16'h5000, RD_DATA);
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    fork
      do_req(0, 1, 0, 16'h4000, 0, 4);
      do_req(1, 1, 0, 16'h5001, 0, 4);
    join
    chk("t2_handover_gap", last_rise - prev_rise, 6);

    // 3) port 0 alone moves the pointer to 1, so the next contention goes to port 1
    push_burst(0, 0, 16'h6000, RD_DATA);
    exp_gnt_q.push_back(2'b01);
    do_req(0, 1, 0, 16'h6002, 0, 4);
    push_burst(1, 0, 16'h8000, RD_DATA);
    push_burst(0, 0, 16'h7000, RD_DATA);
    exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01);
    fork
      do_req(0, 1, 0, 16'h7000, 0, 4);
      do_req(1, 1, 0, 16'h8000, 0, 4);
    join

    // 4) port 1 write-back with rd_1=wr_1=1, memory ready every other cycle
    gap_mode = 1;
    push_burst(1, 1, 16'h0090, WR_DATA);
    exp_gnt_q.push_back(2'b10);
    do_req(1, 1, 1, 16'h0093, WR_DATA, 4);
    gap_mode = 0;

    // 5) reset after the second beat of a read, then a fresh burst
    push_burst(0, 0, 16'h1234, RD_DATA);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exp_gnt_q.push_back(2'b01);
    @(posedge clock); #1 rd_0 = 1; addr_0 = 16'h1236;
    n = 0; budget = 0;
    while (n < 2 && budget < 50) begin
      @(negedge clock);
      if (ready_0) n++;
      budget++;
    end
    chk("t5_two_beats", n, 2);
    hold_mem = 1;
    @(posedge clock); #1 reset = 1; rd_0 = 0;
    @(posedge clock); @(negedge clock);
    chk("t5_reset_abort", {28'b0, rd_mem, gnt, busy}, 0);
    chk("t5_reset_addr_state", {14'b0, state_dbg, addr_mem}, 0);
    #1 reset = 0; hold_mem = 0;
    push_burst(0, 0, 16'h1234, RD_DATA);
    exp_gnt_q.push_back(2'b01);
    do_req(0, 1, 0, 16'h1236, 0, 4);

    // 6) ready_mem in IDLE is ignored; dropping rd_0 mid-burst still runs 4 beats
    repeat (2) @(posedge clock);
    @(negedge clock) force_rdy = 1;
    @(negedge clock);
    chk("t6_idle_ready", {29'b0, ready_mem, ready_1, ready_0}, 32'h4);
    force_rdy = 0;
    @(negedge clock);
    chk("t6_still_idle", {30'b0, state_dbg}, 0);
    push_burst(0, 0, 16'hBEEC, RD_DATA);
    exp_gnt_q.push_back(2'b01);
    do_req(0, 1, 0, 16'hBEEF, 0, 2);
    repeat (2) @(negedge clock);
    chk("t6_back_idle", {28'b0, gnt, busy, state_dbg[0]}, 0);

    repeat (3) @(negedge clock);
    chk("beats_outstanding", exp_q.size(), 0);
    chk("grants_outstanding", exp_gnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got=timeout expected=completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
